// File: rtl/control_compuerta.sv
// Dispense gate controller: drives the gate open, holds it for T_HOLD cycles,
// closes it again, and faults on travel timeout or contradictory limit switches.
module control_compuerta #(
    parameter int T_MOVE = 5_000_000,
    parameter int T_HOLD = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] fc,
    output logic [1:0] motor,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        HOME    = 3'd0,
        IDLE    = 3'd1,
        OPENING = 3'd2,
        HOLD    = 3'd3,
        CLOSING = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [31:0] MOVE_LAST = 32'(T_MOVE - 1);
    localparam logic [31:0] HOLD_LAST = 32'(T_HOLD - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        move_to;

    assign move_to = (cnt_q == MOVE_LAST);

    // Priority: both limits > target limit > abort > timeout/hold expiry > start
    always_comb begin
        state_d = state_q;
        if (fc == 2'b11 && state_q != FAULT) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                HOME: begin
                    if (fc[0])        state_d = IDLE;
                    else if (move_to) state_d = FAULT;
                end
                IDLE: begin
                    if (start)        state_d = OPENING;
                end
                OPENING: begin
                    if (fc[1])        state_d = HOLD;
                    else if (abort)   state_d = CLOSING;
                    else if (move_to) state_d = FAULT;
                end
                HOLD: begin
                    if (abort)                     state_d = CLOSING;
                    else if (cnt_q == HOLD_LAST)   state_d = CLOSING;
                end
                CLOSING: begin
                    if (fc[0])        state_d = IDLE;
                    else if (move_to) state_d = FAULT;
                end
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
        done_d = (state_q == CLOSING) && (state_d == IDLE);
        cnt_d  = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOME;
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        motor = 2'b00;
        busy  = 1'b0;
        error = 1'b0;
        unique case (state_q)
            HOME:    begin motor = 2'b01; busy = 1'b1; end
            OPENING: begin motor = 2'b10; busy = 1'b1; end
            HOLD:    busy = 1'b1;
            CLOSING: begin motor = 2'b01; busy = 1'b1; end
            FAULT:   error = 1'b1;
            default: ;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_control_compuerta.sv
// Directed bench for control_compuerta with T_MOVE=16, T_HOLD=8.
// Outputs are checked as one word {motor, busy, done, error}.
module tb_control_compuerta;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] fc;
    logic [1:0] motor;
    logic       busy, done, error;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] O_HOME  = 5'b01_1_0_0;
    localparam logic [4:0] O_IDLE  = 5'b00_0_0_0;
    localparam logic [4:0] O_DONE  = 5'b00_0_1_0;
    localparam logic [4:0] O_OPEN  = 5'b10_1_0_0;
    localparam logic [4:0] O_HOLD  = 5'b00_1_0_0;
    localparam logic [4:0] O_CLOSE = 5'b01_1_0_0;
    localparam logic [4:0] O_FAULT = 5'b00_0_0_1;

    control_compuerta #(.T_MOVE(16), .T_HOLD(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fc(fc),
        .motor(motor), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {motor, busy, done, error};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fc = 2'b01;
        // reset then home with gate already closed
        tick(); chk("reset_home", O_HOME);
        rst = 1'b0;
        tick(); chk("home_to_idle", O_IDLE);
        tick(); chk("idle_stays", O_IDLE);

        // full dispense: open 5 cycles, hold 8, close 4, done pulse
        start = 1'b1;
        tick(); chk("open_c1", O_OPEN);
        start = 1'b0; fc = 2'b00;
        for (int i = 2; i <= 4; i++) begin tick(); chk("open_mid", O_OPEN); end
        tick(); fc = 2'b10; chk("open_c5_sampling", O_OPEN);
        for (int i = 1; i <= 8; i++) begin tick(); chk("hold_run", O_HOLD); end
        tick(); fc = 2'b00; chk("close_c1", O_CLOSE);
        for (int i = 2; i <= 3; i++) begin tick(); chk("close_mid", O_CLOSE); end
        tick(); fc = 2'b01; chk("close_c4", O_CLOSE);
        tick(); chk("done_pulse", O_DONE);
        tick(); chk("done_once", O_IDLE);

        // entry with open limit already set, abort on hold cycle 3
        start = 1'b1;
        tick(); start = 1'b0; fc = 2'b10; chk("open_limit_preset", O_OPEN);
        tick(); chk("hold_c1", O_HOLD);
        tick(); chk("hold_c2", O_HOLD);
        tick(); abort = 1'b1; chk("hold_c3", O_HOLD);
        tick(); abort = 1'b0; fc = 2'b00; chk("abort_to_close", O_CLOSE);
        tick(); fc = 2'b01; chk("abort_close_c2", O_CLOSE);
        tick(); chk("abort_done", O_DONE);
        tick(); chk("abort_done_once", O_IDLE);

        // limit arrives on the timeout cycle: limit wins
        start = 1'b1;
        tick(); start = 1'b0; fc = 2'b00; chk("late_open_c1", O_OPEN);
        for (int i = 2; i <= 15; i++) begin tick(); chk("late_open_mid", O_OPEN); end
        tick(); fc = 2'b10; chk("late_open_c16", O_OPEN);
        tick(); chk("limit_beats_timeout", O_HOLD);
        abort = 1'b1;
        tick(); abort = 1'b0; fc = 2'b01; chk("late_close", O_CLOSE);
        tick(); chk("late_done", O_DONE);

        // start+abort together in IDLE: start wins; abort then acts in OPENING
        start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; fc = 2'b00; chk("start_over_abort", O_OPEN);
        tick(); abort = 1'b0; chk("abort_in_open", O_CLOSE);
        fc = 2'b01;
        tick(); chk("abort_open_done", O_DONE);

        // both limits during CLOSING -> FAULT, start ignored, rst recovers
        start = 1'b1;
        tick(); start = 1'b0; fc = 2'b10; chk("f_open", O_OPEN);
        tick(); abort = 1'b1; chk("f_hold", O_HOLD);
        tick(); abort = 1'b0; fc = 2'b11; chk("f_close", O_CLOSE);
        tick(); fc = 2'b01; start = 1'b1; chk("fc11_fault", O_FAULT);
        tick(); chk("fault_ignores_start", O_FAULT);
        tick(); start = 1'b0; chk("fault_sticky", O_FAULT);
        rst = 1'b1;
        tick(); rst = 1'b0; chk("fault_rst_home", O_HOME);
        tick(); chk("fault_rst_idle", O_IDLE);

        // opening timeout: 16 cycles of drive then FAULT
        start = 1'b1;
        tick(); start = 1'b0; fc = 2'b00; chk("to_open_c1", O_OPEN);
        for (int i = 2; i <= 16; i++) begin tick(); chk("to_open_run", O_OPEN); end
        tick(); chk("open_timeout_fault", O_FAULT);
        for (int i = 0; i < 3; i++) begin tick(); chk("timeout_fault_holds", O_FAULT); end

        // HOME timeout with gate never reaching closed
        rst = 1'b1;
        tick(); rst = 1'b0; chk("home_c1", O_HOME);
        for (int i = 2; i <= 16; i++) begin tick(); chk("home_run", O_HOME); end
        tick(); chk("home_timeout_fault", O_FAULT);

        // reset mid-opening discards the dispense with no done
        rst = 1'b1; fc = 2'b01;
        tick(); rst = 1'b0; chk("r_home", O_HOME);
        tick(); chk("r_idle", O_IDLE);
        start = 1'b1;
        tick(); start = 1'b0; fc = 2'b00; chk("r_open", O_OPEN);
        rst = 1'b1;
        tick(); rst = 1'b0; fc = 2'b01; chk("rst_mid_open", O_HOME);
        tick(); chk("rst_mid_no_done", O_IDLE);

        // both limits in IDLE also faults
        fc = 2'b11;
        tick(); fc = 2'b01; chk("idle_fc11_fault", O_FAULT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
